// File: rtl/sine_dds.sv
// sine_dds: phase-accumulator sine generator with a quarter-wave ROM and
// wrap-synchronised tuning-word updates; unsigned offset-binary samples.
`default_nettype none

module sine_dds #(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] ftw,
    input  logic               ftw_load,
    input  logic               phase_clr,
    output logic [DATA_W-1:0]  data,
    output logic               data_valid,
    output logic               wrap
);

    localparam int  ROM_AW    = ADDR_W - 2;
    localparam int  ROM_DEPTH = 1 << ROM_AW;
    localparam int  MAG_W     = DATA_W - 1;
    localparam real PI        = 3.14159265358979323846;
    localparam real AMP       = real'((1 << MAG_W) - 1);
    localparam real STEP      = PI / real'(1 << (ADDR_W - 1));

    logic [MAG_W-1:0] rom [ROM_DEPTH];

    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
        localparam int MAG = $rtoi(AMP * $sin((real'(i) + 0.5) * STEP) + 0.5);
        assign rom[i] = MAG_W'(MAG);
    end

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] ftw_active;
    logic [PHASE_W-1:0] pend;
    logic               pend_flag;
    logic [PHASE_W:0]   sum;
    logic               carry;
    logic               swap;

    always_comb begin
        sum   = {1'b0, acc} + {1'b0, ftw_active};
        carry = en & ~phase_clr & sum[PHASE_W];
        // With nothing pending, pend already equals ftw_active, so gating is lossless.
        swap  = pend_flag & (phase_clr | (ftw_active == '0) | carry);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            ftw_active <= '0;
            pend       <= '0;
            pend_flag  <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            if (phase_clr) begin
                acc <= '0;
            end else if (en) begin
                acc <= sum[PHASE_W-1:0];
            end
            if (swap) begin
                ftw_active <= pend;
            end
            if (ftw_load) begin
                pend      <= ftw;
                pend_flag <= 1'b1;
            end else if (swap) begin
                pend_flag <= 1'b0;
            end
            wrap <= carry;
        end
    end

    logic [1:0]        quad;
    logic [ROM_AW-1:0] idx;
    logic              s1_neg;
    logic [ROM_AW-1:0] s1_addr;
    logic              s2_neg;
    logic [MAG_W-1:0]  s2_mag;
    logic [2:0]        fill;

    assign quad = acc[PHASE_W-1 -: 2];
    assign idx  = acc[PHASE_W-3 -: ROM_AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_neg  <= 1'b0;
            s1_addr <= '0;
            s2_neg  <= 1'b0;
            s2_mag  <= '0;
            data    <= '0;
            fill    <= '0;
        end else if (en) begin
            s1_neg  <= quad[1];
            s1_addr <= quad[0] ? ~idx : idx;
            s2_neg  <= s1_neg;
            s2_mag  <= rom[s1_addr];
            // mid + mag is {1,mag}; mid - 1 - mag is {0,~mag}.
            data    <= s2_neg ? {1'b0, ~s2_mag} : {1'b1, s2_mag};
            fill    <= {fill[1:0], 1'b1};
        end
    end

    assign data_valid = fill[2];

endmodule

`default_nettype wire
